// File: rtl/ula_param.sv
// Purpose: WIDTH-bit ALU (logic, add/sub, shifts, iterative unsigned multiply) with registered result and flags.
// Latency: 1 cycle for single-cycle ops; WIDTH cycles after acceptance for multiply.
// Backpressure: requests are taken only in IDLE; busy is high during a multiply and ena is ignored.
module ula_param #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       op_sel,
    output logic [WIDTH-1:0] res,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             ula_ack
);

    localparam int MSB = WIDTH - 1;
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;
    state_t state;

    // Multiply datapath: the multiplicand shifts left and the multiplier shifts
    // right, so each iteration only ever inspects multiplier bit 0.
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;

    // Single-cycle ALU. Shifts run one bit wider so the last bit shifted out
    // lands in the extra bit, which also gives C=0 for a zero shift amount.
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH:0]   sra_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             is_mul;

    assign amt    = op2[SHW-1:0];
    assign sum_w  = {1'b0, op1} + {1'b0, op2};
    assign dif_w  = {1'b0, op1} - {1'b0, op2};
    assign shl_w  = {1'b0, op1} << amt;
    assign shr_w  = {op1, 1'b0} >> amt;
    assign sra_w  = $signed({op1, 1'b0}) >>> amt;
    assign is_mul = (op_sel == 4'b0000);

    // Accumulate the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end
    end

    // Decode op_sel into the single-cycle result and its carry/overflow flags
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        casez (op_sel)
            4'b0001: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            4'b0010: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            4'b0011: begin
                alu_res = sra_w[WIDTH:1];
                alu_c   = sra_w[0];
            end
            4'b0100: alu_res = op1 | op2;
            4'b0101: alu_res = op1 & op2;
            4'b0110: alu_res = op1 ^ op2;
            4'b0111: alu_res = ~(op1 & op2);
            4'b10??: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (op1[MSB] == op2[MSB]) && (sum_w[MSB] != op1[MSB]);
            end
            4'b11??: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_c   = dif_w[WIDTH];
                alu_v   = (op1[MSB] != op2[MSB]) && (dif_w[MSB] != op1[MSB]);
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
        endcase
    end

    // Control FSM: single-cycle ops complete in IDLE, multiply iterates in MUL
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            res     <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            busy    <= 1'b0;
            ula_ack <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ena && is_mul) begin
                        mcand   <= {{WIDTH{1'b0}}, op1};
                        mplier  <= op2;
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        ula_ack <= 1'b0;
                        state   <= MUL;
                    end else if (ena) begin
                        res     <= alu_res;
                        flag_z  <= (alu_res == '0);
                        flag_n  <= alu_res[MSB];
                        flag_c  <= alu_c;
                        flag_v  <= alu_v;
                        ula_ack <= 1'b1;
                    end else begin
                        ula_ack <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        res     <= acc_nxt[WIDTH-1:0];
                        flag_z  <= (acc_nxt[WIDTH-1:0] == '0);
                        flag_n  <= acc_nxt[MSB];
                        flag_c  <= |acc_nxt[2*WIDTH-1:WIDTH];
                        flag_v  <= 1'b0;
                        ula_ack <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ula_ack <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ula_param.md
Name: ula_param

Overview:
Parametrised successor to the team's 4-bit ULA. It provides a WIDTH-bit ALU with the same op_sel encoding for logic and add/sub, plus shift and multiply operations. Multiply is multi-cycle (iterative shift-add), so the block carries a busy/ack handshake and registered status flags. It sits between the datapath operand registers and the result bus, driven by the control FSM.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4
SHW, $clog2(WIDTH), derived: shift-amount bits taken from op2

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
ena  input  1  operation request; sampled only in IDLE
op1  input  WIDTH  operand A
op2  input  WIDTH  operand B / shift amount (low SHW bits)
op_sel  input  4  operation select
res  output  WIDTH  registered result
flag_z  output  1  result zero
flag_n  output  1  result MSB
flag_c  output  1  carry/borrow/shift-out/mul-overflow
flag_v  output  1  signed overflow (add/sub only)
busy  output  1  multiply in progress
ula_ack  output  1  one-cycle result-valid pulse

Behaviour:
- Reset (rst=1 at edge): res=0, all flags=0, ula_ack=0, busy=0, state=IDLE. Reset overrides ena and aborts any multiply in progress; no ack is issued for it.
- States: IDLE, MUL.
- op_sel decode (casex):
  - 0000 MUL
  - 0001 SHL
  - 0010 SHR (logical)
  - 0011 SRA
  - 0100 OR
  - 0101 AND
  - 0110 XOR
  - 0111 NAND
  - 10xx ADD
  - 11xx SUB
- IDLE, ena=0: ula_ack<=0; res and flags hold.
- IDLE, ena=1, non-MUL op: at the same edge, res and flags are updated and ula_ack<=1; state stays IDLE. Latency is 1 cycle. With ena held high, a new result and ack are produced every cycle.
- IDLE, ena=1, MUL: at edge k, op1/op2 are captured internally, the partial product and iteration counter are cleared, busy<=1, ula_ack<=0, state<=MUL.
- MUL: one shift-add iteration per edge; ena is ignored.
  - At edge k+WIDTH: res<=low WIDTH bits of the product, flags updated, ula_ack<=1, busy<=0, state<=IDLE.
  - busy is high for exactly WIDTH cycles. The next request is accepted at edge k+WIDTH+1 at the earliest.
- Operands are registered at acceptance. Changes to op1/op2/op_sel during MUL have no effect.
- Arithmetic: all results are truncated to WIDTH bits (mod 2^WIDTH).
  - ADD: C=carry out. V=1 when both operands have the same sign and the result sign differs.
  - SUB (op1-op2): C=borrow (1 iff op1<op2 unsigned). V=1 when operand signs differ and the result sign differs from op1.
  - MUL: unsigned. C=1 iff the upper WIDTH bits of the full 2*WIDTH product are nonzero. V=0.
  - Shifts: amount = op2[SHW-1:0]; amount 0 passes op1 with C=0. Otherwise C=last bit shifted out (SHL: op1[WIDTH-amt]; SHR/SRA: op1[amt-1]). SRA replicates op1 MSB. V=0.
  - Logic ops: C=0, V=0.
- Z and N always derive from the new res. Flags change only on an ack edge (or reset).
- ula_ack is never high for two consecutive cycles from one MUL. For single-cycle ops, ack is high only while requests keep arriving.

Test Plan:
1. WIDTH=8. ADD op1=200, op2=100, ena one cycle -> next cycle res=44, C=1, V=0, Z=0, N=0, ula_ack=1 for exactly one cycle.
2. SUB 0x80-0x01 -> res=0x7F, V=1, C=0, N=0. SUB 0x05-0x07 -> res=0xFE, C=1, N=1, V=0.
3. MUL 15*17 -> busy high 8 cycles, then res=0xFF, C=0, single ack. MUL 16*16 -> res=0x00, Z=1, C=1.
4. SHL 0x81 by 1 -> res=0x02, C=1. SRA 0x90 by 2 -> res=0xE4, C=0. SHR 0x90 by 4 -> res=0x09, C=0. Shift by 0 -> res=op1, C=0.
5. ena+ADD asserted on every cycle during a MUL -> no extra ack, MUL result correct, ADD accepted only after MUL ack. ena+XOR held for 3 cycles in IDLE -> 3 consecutive acks with per-cycle results.
6. rst asserted at iteration 4 of MUL -> next cycle busy=0, ula_ack=0, res=0, flags=0; no ack follows. A subsequent OR 0x0F|0xF0 -> res=0xFF, N=1.
